// File: rtl/bias_mem_param.sv
// Signed bias memory of LAYERS x NEURONS entries with a 1-cycle registered read and a zeroing sweep FSM.
// Optional macro BIAS_PARITY_EN adds an even-parity bit per entry and the par_err read flag.
module bias_mem_param #(
  parameter int BIAS_W  = 8,
  parameter int LAYERS  = 3,
  parameter int NEURONS = 16,
  parameter int ADDR_W  = 16,
  localparam int LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int NW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [BIAS_W-1:0] bias_val,
  output logic                     rd_valid,
  output logic                     addr_err,
  input  logic                     wr_en,
  input  logic [LW-1:0]            wr_layer,
  input  logic [NW-1:0]            wr_neuron,
  input  logic signed [BIAS_W-1:0] wr_data,
  output logic                     wr_ready,
  input  logic                     clear,
  output logic                     busy,
  output logic                     par_err
);
  localparam int DEPTH = LAYERS * NEURONS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef BIAS_PARITY_EN
  localparam int MW    = BIAS_W + 1;
`else
  localparam int MW    = BIAS_W;
`endif
  localparam logic [LW:0] LAYER_LIM  = (LW + 1)'(LAYERS);
  localparam logic [NW:0] NEURON_LIM = (NW + 1)'(NEURONS);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [BIAS_W-1:0] bias_val_q, bias_val_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     addr_err_q, addr_err_d;
  logic                     par_err_q, par_err_d;

  logic [MW-1:0]            mem_q [DEPTH];
  logic                     mem_we;
  logic [IW-1:0]            mem_widx;
  logic [MW-1:0]            mem_wdata;

  logic [LW-1:0]            rd_layer;
  logic [NW-1:0]            rd_neuron;
  logic                     rd_ok, wr_ok;
  logic [IW-1:0]            rd_idx, wr_idx;
  logic [MW-1:0]            rd_word, wr_word;

  always_comb begin
    rd_layer  = rd_addr[ADDR_W-1 -: LW];
    rd_neuron = rd_addr[ADDR_W-1-LW -: NW];
    rd_ok     = ({1'b0, rd_layer} < LAYER_LIM) && ({1'b0, rd_neuron} < NEURON_LIM);
    wr_ok     = ({1'b0, wr_layer} < LAYER_LIM) && ({1'b0, wr_neuron} < NEURON_LIM);
    rd_idx    = rd_ok ? IW'(int'(rd_layer) * NEURONS + int'(rd_neuron)) : '0;
    wr_idx    = wr_ok ? IW'(int'(wr_layer) * NEURONS + int'(wr_neuron)) : '0;
    // mem_q is read before this edge's write lands, so same-index read/write is read-first
    rd_word   = rd_ok ? mem_q[rd_idx] : '0;
`ifdef BIAS_PARITY_EN
    wr_word   = {^wr_data, wr_data};
`else
    wr_word   = wr_data;
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bias_val_d = bias_val_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    par_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = wr_idx;
    mem_wdata  = wr_word;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (wr_en && wr_ok) begin
          mem_we = 1'b1;
        end
        if (rd_req) begin
          rd_valid_d = 1'b1;
          addr_err_d = ~rd_ok;
          bias_val_d = rd_ok ? rd_word[BIAS_W-1:0] : '0;
`ifdef BIAS_PARITY_EN
          par_err_d  = rd_ok && (^rd_word);
`endif
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = idx_q;
        mem_wdata = '0;
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Reset parks the FSM in CLEAR so every release starts a full sweep from index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      bias_val_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bias_val_q <= bias_val_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
      par_err_q  <= par_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign busy     = (state_q == CLEAR);
  assign wr_ready = ~busy;
  assign bias_val = bias_val_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign par_err  = par_err_q;
endmodule
